out_rd_ctrl: RTL
================

OUT_RD_CTRL -- requirements
Module: out_rd_ctrl

Interface
REQ-001 SHALL have parameter PORT_NUB, default `PORT_NUB_TOTAL: number of source queues feeding this output port.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH: payload width.
REQ-003 SHALL have parameter BURST, default 2: max consecutive grants to one source (range 1..16).
REQ-004 SHALL define localparam WIDTH_SEL = $clog2(PORT_NUB).
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port empty_in  input  PORT_NUB  per-source queue empty flag; bit s is 1 when queue s is empty; it already reflects a pop issued in the previous cycle.
REQ-008 SHALL have port rd_en_out  output  PORT_NUB  one-hot-or-zero pop strobe to the source queues.
REQ-009 SHALL have port rd_data_in  input  DATA_WIDTH  queue read data, valid exactly 1 cycle after rd_en_out.
REQ-010 SHALL have port out_valid  output  1  head entry of the output buffer is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head entry when out_valid and out_ready are both 1.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  head payload.
REQ-013 SHALL have port out_src  output  WIDTH_SEL  source index of the head payload.

Function
REQ-014 SHALL keep a 2-entry in-order output FIFO (cnt in 0..2) with payload and source index per entry.
REQ-015 SHALL track inflight (0/1) = read issued last cycle, data arriving this cycle.
REQ-016 SHALL define pop = out_valid & out_ready; issue is permitted only when cnt + inflight - pop < 2, so cnt never exceeds 2.
REQ-017 SHALL keep cur (last granted source) and burst_cnt (grants to cur in the current burst).
REQ-018 SHALL select the source as follows: if issue permitted, empty_in[cur]=0, and burst_cnt<BURST, select cur; else select the first s with empty_in[s]=0 searching cur+1, cur+2, ... modulo PORT_NUB, including cur last.
REQ-019 SHALL drive rd_en_out combinationally as a one-hot of the selected source when issue is permitted and any queue is non-empty, else all zero.
REQ-020 SHALL on a grant to the same source as cur increment burst_cnt, and on a grant to a different source set cur to it and burst_cnt to 1.
REQ-021 SHALL leave cur and burst_cnt unchanged in a cycle with no grant.
REQ-022 SHALL write rd_data_in and the granted index into the FIFO at the end of the cycle after the grant; out_valid rises 2 cycles after rd_en_out.
REQ-023 SHALL handle a simultaneous FIFO write and pop in one cycle with no loss and no reordering.
REQ-024 SHALL sustain one transfer per cycle while out_ready=1 and at least one queue is non-empty.
REQ-025 SHALL assert out_valid = (cnt != 0) and hold out_data/out_src stable while out_valid=1 and out_ready=0.

Reset
REQ-026 SHALL when rst_n=0 at a clock edge clear cnt, inflight, burst_cnt and out_data/out_src to 0, and set cur to PORT_NUB-1 so the first search starts at source 0.
REQ-027 SHALL hold rd_en_out=0 and out_valid=0 throughout reset; a reset mid-burst discards buffered and in-flight data.

Verification (PORT_NUB=4, BURST=2, DATA_WIDTH=8)
REQ-028 SHALL cover: reset, empty_in=4'b1111, out_ready=1 for 10 cycles -> rd_en_out=0 and out_valid=0 throughout.
REQ-029 SHALL cover: only queue 2 non-empty at cycle T, data 8'hA5 -> rd_en_out=4'b0100 at T; out_valid=1, out_data=8'hA5, out_src=2 at T+2.
REQ-030 SHALL cover: queues 0, 1 and 3 permanently non-empty, out_ready=1 -> grant order 0,0,1,1,3,3,0,0,... with one grant per cycle.
REQ-031 SHALL cover: all queues non-empty, out_ready=0 -> exactly 2 rd_en_out pulses, then stall with cnt=2; after out_ready=1, both entries leave in order and issue resumes within the same cycle.
REQ-032 SHALL cover: rst_n=0 in the cycle after a grant, with inflight=1 -> out_valid stays 0 and the next grant after reset goes to source 0.
REQ-033 SHALL cover: out_ready toggled randomly, sources random -> each source's payload sequence is received in order with no drop or duplicate, and cnt stays <= 2.

Source files
------------

// File: rtl/out_rd_ctrl.sv
// Output-port read controller: round-robin-with-burst pop of source queues into
// a 2-entry in-order output buffer tagged with the source index.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module out_rd_ctrl #(
  parameter int PORT_NUB   = `PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int BURST      = 2,
  localparam int WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_NUB-1:0]   empty_in,
  output logic [PORT_NUB-1:0]   rd_en_out,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [WIDTH_SEL-1:0]  out_src
);

  logic [1:0]            cnt;
  logic                  inflight;
  logic [WIDTH_SEL-1:0]  infl_src;
  logic [WIDTH_SEL-1:0]  cur;
  logic [4:0]            burst_cnt;
  logic [DATA_WIDTH-1:0] mem_data [2];
  logic [WIDTH_SEL-1:0]  mem_src  [2];

  logic                  pop;
  logic                  issue_ok;
  logic                  any_ne;
  logic                  grant;
  logic                  found;
  logic [2:0]            occ;
  logic [WIDTH_SEL-1:0]  sel;
  logic [WIDTH_SEL-1:0]  cand;

  assign out_valid = rst_n && (cnt != 2'd0);
  assign out_data  = mem_data[0];
  assign out_src   = mem_src[0];

  always_comb begin
    pop       = out_valid & out_ready;
    occ       = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    issue_ok  = rst_n && (occ < 3'd2);
    any_ne    = ~&empty_in;
    grant     = issue_ok & any_ne;
    sel       = cur;
    cand      = cur;
    found     = 1'b0;
    rd_en_out = '0;
    // burst_cnt==0 only after reset: no burst is open, so search from cur+1
    if (!empty_in[cur] && burst_cnt != 5'd0 && burst_cnt < 5'(BURST)) begin
      found = 1'b1;
    end else begin
      for (int i = 1; i <= PORT_NUB; i++) begin
        cand = WIDTH_SEL'((int'(cur) + i) % PORT_NUB);
        if (!found && !empty_in[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
    if (grant) rd_en_out[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= 2'd0;
      inflight    <= 1'b0;
      infl_src    <= '0;
      cur         <= WIDTH_SEL'(PORT_NUB - 1);
      burst_cnt   <= 5'd0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_src[0]  <= '0;
      mem_src[1]  <= '0;
    end else begin
      inflight <= grant;
      if (grant) begin
        infl_src <= sel;
        if (sel == cur) begin
          if (burst_cnt < 5'(BURST)) burst_cnt <= burst_cnt + 5'd1;
        end else begin
          cur       <= sel;
          burst_cnt <= 5'd1;
        end
      end
      // head is always mem[0]; a pop shifts mem[1] forward
      case ({inflight, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            mem_data[0] <= rd_data_in;
            mem_src[0]  <= infl_src;
          end else begin
            mem_data[1] <= rd_data_in;
            mem_src[1]  <= infl_src;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem_data[0] <= mem_data[1];
          mem_src[0]  <= mem_src[1];
          cnt         <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            mem_data[0] <= rd_data_in;
            mem_src[0]  <= infl_src;
          end else begin
            mem_data[0] <= mem_data[1];
            mem_src[0]  <= mem_src[1];
            mem_data[1] <= rd_data_in;
            mem_src[1]  <= infl_src;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
